// File: rtl/pacman_gfx_pkg.sv
// Shared graphics definitions: framebuffer geometry, blank colour, controller states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pacman_gfx_pkg;

    localparam logic [7:0]  BLK         = 8'h00;      // colour shown for off-screen reads
    localparam int          FB_PIXELS   = 63360;      // 240 x 264 pixels per bank
    localparam logic [15:0] FB_ADDR_MAX = 16'hFFFF;   // display's off-screen address

    typedef enum logic [1:0] {
        IDLE,
        RENDER,
        WAIT,
        SWAP
    } fb_state_t;

endpackage

// File: rtl/framebuffer_pingpong_ctrl_if.sv
// Renderer <-> framebuffer controller write channel (valid/ready plus frame pulses).
// Latency: n/a (signal bundle only).
// Backpressure: wr_ready gates every write; render_start/render_done are single-cycle pulses.
//   master: renderer (drives wr_valid/wr_addr/wr_data/render_done)
//   slave : controller (drives wr_ready/render_start)
interface framebuffer_pingpong_ctrl_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic              render_start;
    logic              render_done;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (
        input  render_start, wr_ready,
        output render_done, wr_valid, wr_addr, wr_data
    );

    modport slave (
        output render_start, wr_ready,
        input  render_done, wr_valid, wr_addr, wr_data
    );
endinterface

// File: rtl/framebuffer_pingpong_ctrl_bank_mux.sv
// Steers the front (read-only) and back (write) bank requests onto RAM A / RAM B.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; the front bank's write enable is tied low here.
//   in : front_sel, front_addr, back_addr/back_we/back_wdata
//   out: ram_a_addr/we/wdata, ram_b_addr/we/wdata
module fb_bank_mux #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic              front_sel,
    input  logic [ADDR_W-1:0] front_addr,
    input  logic [ADDR_W-1:0] back_addr,
    input  logic              back_we,
    input  logic [DATA_W-1:0] back_wdata,
    output logic [ADDR_W-1:0] ram_a_addr,
    output logic              ram_a_we,
    output logic [DATA_W-1:0] ram_a_wdata,
    output logic [ADDR_W-1:0] ram_b_addr,
    output logic              ram_b_we,
    output logic [DATA_W-1:0] ram_b_wdata
);
    always_comb begin
        ram_a_addr  = front_addr;
        ram_a_we    = 1'b0;
        ram_a_wdata = '0;
        ram_b_addr  = back_addr;
        ram_b_we    = back_we;
        ram_b_wdata = back_wdata;
        if (front_sel) begin
            ram_a_addr  = back_addr;
            ram_a_we    = back_we;
            ram_a_wdata = back_wdata;
            ram_b_addr  = front_addr;
            ram_b_we    = 1'b0;
            ram_b_wdata = '0;
        end
    end
endmodule

// File: rtl/framebuffer_pingpong_ctrl.sv
// Ping-pong maze framebuffer: display reads the front bank, renderer fills the back bank, swap in vblank.
// Latency: maze_color 1 cycle after rd_addr; writes reach the RAM pins in the accepting cycle.
// Backpressure: wr_ready only in RENDER; finished frames wait for the next unused vertical blank.
//   in : clk, rst, vc, rd_addr, ram_a_rdata, ram_b_rdata, wr (slave: wr_valid/wr_addr/wr_data/render_done)
//   out: maze_color, ram_a_*/ram_b_* addr/we/wdata, front_sel, frame_count, wr_err, wr (render_start/wr_ready)
module framebuffer_pingpong_ctrl #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 8,
    parameter int FB_PIXELS = pacman_gfx_pkg::FB_PIXELS,
    parameter int VACTIVE   = 480
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [9:0]        vc,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] maze_color,
    framebuffer_pingpong_ctrl_if.slave wr,
    output logic [ADDR_W-1:0] ram_a_addr,
    output logic              ram_a_we,
    output logic [DATA_W-1:0] ram_a_wdata,
    input  logic [DATA_W-1:0] ram_a_rdata,
    output logic [ADDR_W-1:0] ram_b_addr,
    output logic              ram_b_we,
    output logic [DATA_W-1:0] ram_b_wdata,
    input  logic [DATA_W-1:0] ram_b_rdata,
    output logic              front_sel,
    output logic [7:0]        frame_count,
    output logic              wr_err
);
    import pacman_gfx_pkg::*;

    localparam logic [ADDR_W-1:0] FB_LIMIT = ADDR_W'(FB_PIXELS);
    localparam logic [9:0]        VBLANK   = 10'(VACTIVE);

    fb_state_t         state, state_nxt;
    logic              start_nxt;
    logic              render_start_q;
    logic              swapped_this_blank;
    logic              rd_vld_q;
    logic              rd_sel_q;
    logic              in_blank;
    logic              rd_in_range;
    logic              wr_in_range;
    logic              wr_fire;
    logic              back_we;
    logic [ADDR_W-1:0] back_addr;
    logic [ADDR_W-1:0] front_addr;

    assign in_blank    = (vc >= VBLANK);
    assign rd_in_range = (rd_addr < FB_LIMIT);
    assign wr_in_range = (wr.wr_addr < FB_LIMIT);

    // Gating with rst makes a mid-render reset drop we in the same cycle,
    // before the synchronous state reset takes effect.
    assign wr.wr_ready    = (state == RENDER) && !rst;
    assign wr.render_start = render_start_q;
    assign wr_fire        = wr.wr_valid && wr.wr_ready;

    // Out-of-range writes are accepted (handshake completes) but never reach the RAM.
    assign back_we    = wr_fire && wr_in_range;
    assign back_addr  = back_we ? wr.wr_addr : '0;
    assign front_addr = rd_in_range ? rd_addr : '0;

    fb_bank_mux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_bank_mux (
        .front_sel   (front_sel),
        .front_addr  (front_addr),
        .back_addr   (back_addr),
        .back_we     (back_we),
        .back_wdata  (wr.wr_data),
        .ram_a_addr  (ram_a_addr),
        .ram_a_we    (ram_a_we),
        .ram_a_wdata (ram_a_wdata),
        .ram_b_addr  (ram_b_addr),
        .ram_b_we    (ram_b_we),
        .ram_b_wdata (ram_b_wdata)
    );

    always_comb begin
        state_nxt = state;
        start_nxt = 1'b0;
        case (state)
            IDLE: begin
                state_nxt = RENDER;
                start_nxt = 1'b1;
            end
            RENDER: begin
                if (wr.render_done) state_nxt = WAIT;
            end
            WAIT: begin
                if (in_blank && !swapped_this_blank) state_nxt = SWAP;
            end
            SWAP: begin
                state_nxt = RENDER;
                start_nxt = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            render_start_q     <= 1'b0;
            front_sel          <= 1'b0;
            frame_count        <= 8'd0;
            wr_err             <= 1'b0;
            swapped_this_blank <= 1'b0;
            rd_vld_q           <= 1'b0;
            rd_sel_q           <= 1'b0;
        end else begin
            state          <= state_nxt;
            render_start_q <= start_nxt;
            // Bank choice travels with the read so a swap never mixes banks mid-read.
            rd_vld_q       <= rd_in_range;
            rd_sel_q       <= front_sel;
            if (wr_fire && !wr_in_range) wr_err <= 1'b1;
            if (state == SWAP) begin
                front_sel          <= ~front_sel;
                frame_count        <= frame_count + 8'd1;
                swapped_this_blank <= 1'b1;
            end else if (!in_blank) begin
                swapped_this_blank <= 1'b0;
            end
        end
    end

    assign maze_color = rd_vld_q ? (rd_sel_q ? ram_b_rdata : ram_a_rdata) : DATA_W'(BLK);

endmodule

// File: tb/tb_framebuffer_pingpong_ctrl.sv
// Directed bench for framebuffer_pingpong_ctrl with behavioural sync RAMs on both banks.
// Latency: n/a.
// Backpressure: n/a.
module tb_framebuffer_pingpong_ctrl;
    import pacman_gfx_pkg::*;

    logic        clk;
    logic        rst;
    logic [9:0]  vc;
    logic [15:0] rd_addr;
    logic [7:0]  maze_color;
    logic [15:0] ram_a_addr, ram_b_addr;
    logic        ram_a_we, ram_b_we;
    logic [7:0]  ram_a_wdata, ram_b_wdata;
    logic [7:0]  ram_a_rdata, ram_b_rdata;
    logic        front_sel;
    logic [7:0]  frame_count;
    logic        wr_err;

    int n_chk = 0;
    int n_bad = 0;

    logic [7:0] mem_a [0:65535];
    logic [7:0] mem_b [0:65535];

    framebuffer_pingpong_ctrl_if #(.ADDR_W(16), .DATA_W(8)) wr_if ();

    framebuffer_pingpong_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .vc          (vc),
        .rd_addr     (rd_addr),
        .maze_color  (maze_color),
        .wr          (wr_if),
        .ram_a_addr  (ram_a_addr),
        .ram_a_we    (ram_a_we),
        .ram_a_wdata (ram_a_wdata),
        .ram_a_rdata (ram_a_rdata),
        .ram_b_addr  (ram_b_addr),
        .ram_b_we    (ram_b_we),
        .ram_b_wdata (ram_b_wdata),
        .ram_b_rdata (ram_b_rdata),
        .front_sel   (front_sel),
        .frame_count (frame_count),
        .wr_err      (wr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read-first synchronous RAMs, one-cycle read latency.
    always @(posedge clk) begin
        if (ram_a_we) mem_a[ram_a_addr] <= ram_a_wdata;
        ram_a_rdata <= mem_a[ram_a_addr];
        if (ram_b_we) mem_b[ram_b_addr] <= ram_b_wdata;
        ram_b_rdata <= mem_b[ram_b_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem_a[i] = 8'h00;
            mem_b[i] = 8'h00;
        end
        rst = 1'b1;
        vc = 10'd0;
        rd_addr = FB_ADDR_MAX;
        wr_if.wr_valid = 1'b0;
        wr_if.wr_addr = 16'd0;
        wr_if.wr_data = 8'd0;
        wr_if.render_done = 1'b0;
        repeat (3) tick();

        // Reset state
        chk("rst_front_sel", front_sel, 0);
        chk("rst_frame_count", frame_count, 0);
        chk("rst_wr_err", wr_err, 0);
        chk("rst_render_start", wr_if.render_start, 0);
        chk("rst_wr_ready", wr_if.wr_ready, 0);
        chk("rst_we_a", ram_a_we, 0);
        chk("rst_we_b", ram_b_we, 0);
        chk("rst_maze_color", maze_color, 0);

        // Idle -> render: exactly one start pulse
        rst = 1'b0;
        #1;
        chk("idle_start_low", wr_if.render_start, 0);
        tick();
        chk("start_pulse", wr_if.render_start, 1);
        chk("render_ready", wr_if.wr_ready, 1);
        tick();
        chk("start_pulse_end", wr_if.render_start, 0);

        // Write 0xA5 @100 goes to bank B (back)
        wr_if.wr_valid = 1'b1; wr_if.wr_addr = 16'd100; wr_if.wr_data = 8'hA5;
        #1;
        chk("wr_b_we", ram_b_we, 1);
        chk("wr_b_addr", ram_b_addr, 100);
        chk("wr_b_wdata", ram_b_wdata, 8'hA5);
        chk("wr_a_we", ram_a_we, 0);
        tick();

        // render_done together with a write at vc=300: write lands, then WAIT
        vc = 10'd300;
        wr_if.wr_addr = 16'd101; wr_if.wr_data = 8'h5A; wr_if.render_done = 1'b1;
        #1;
        chk("done_wr_b_we", ram_b_we, 1);
        tick();
        wr_if.render_done = 1'b0;
        wr_if.wr_addr = 16'd102; wr_if.wr_data = 8'hEE;
        #1;
        chk("wait_ready", wr_if.wr_ready, 0);
        chk("wait_no_we", ram_b_we, 0);
        wr_if.wr_valid = 1'b0;
        repeat (3) tick();
        chk("wait_no_swap_fs", front_sel, 0);
        chk("wait_no_swap_fc", frame_count, 0);

        // Enter vblank: WAIT -> SWAP -> RENDER
        vc = 10'd480;
        tick();
        chk("swap_pending_fs", front_sel, 0);
        tick();
        chk("swap1_fs", front_sel, 1);
        chk("swap1_fc", frame_count, 1);
        chk("swap1_start", wr_if.render_start, 1);

        // Read back the frame that is now in front
        rd_addr = 16'd100;
        tick();
        chk("rd_100", maze_color, 8'hA5);
        rd_addr = 16'd101;
        tick();
        chk("rd_101", maze_color, 8'h5A);
        rd_addr = 16'd102;
        tick();
        chk("rd_102_dropped", maze_color, 8'h00);
        rd_addr = FB_ADDR_MAX;
        tick();
        chk("rd_offscreen", maze_color, 8'h00);

        // Next render writes bank A
        wr_if.wr_valid = 1'b1; wr_if.wr_addr = 16'd7; wr_if.wr_data = 8'h11;
        #1;
        chk("wr2_a_we", ram_a_we, 1);
        chk("wr2_a_addr", ram_a_addr, 7);
        chk("wr2_b_we", ram_b_we, 0);
        tick();
        wr_if.wr_valid = 1'b0;

        // Second done inside the same blank: must wait for the next blank
        wr_if.render_done = 1'b1;
        tick();
        wr_if.render_done = 1'b0;
        vc = 10'd490;
        repeat (3) tick();
        chk("same_blank_fs", front_sel, 1);
        chk("same_blank_fc", frame_count, 1);
        vc = 10'd10;
        tick();
        vc = 10'd480;
        tick();
        tick();
        chk("next_blank_fs", front_sel, 0);
        chk("next_blank_fc", frame_count, 2);

        // Out-of-range write: dropped, sticky error
        wr_if.wr_valid = 1'b1; wr_if.wr_addr = 16'd63360; wr_if.wr_data = 8'hFF;
        #1;
        chk("oor_ready", wr_if.wr_ready, 1);
        chk("oor_we_a", ram_a_we, 0);
        chk("oor_we_b", ram_b_we, 0);
        tick();
        wr_if.wr_valid = 1'b0;
        chk("oor_err", wr_err, 1);
        repeat (2) tick();
        chk("oor_err_sticky", wr_err, 1);

        // Reset mid-render with a pending write
        wr_if.wr_valid = 1'b1; wr_if.wr_addr = 16'd200; wr_if.wr_data = 8'h77;
        rst = 1'b1;
        #1;
        chk("midrst_we_a", ram_a_we, 0);
        chk("midrst_we_b", ram_b_we, 0);
        chk("midrst_ready", wr_if.wr_ready, 0);
        tick();
        chk("midrst_fs", front_sel, 0);
        chk("midrst_fc", frame_count, 0);
        chk("midrst_err", wr_err, 0);
        wr_if.wr_valid = 1'b0;
        rst = 1'b0;
        vc = 10'd0;
        tick();
        chk("midrst_restart", wr_if.render_start, 1);

        // 256 swaps: frame_count wraps back to 0
        for (int i = 0; i < 256; i++) begin
            wr_if.render_done = 1'b1;
            tick();
            wr_if.render_done = 1'b0;
            vc = 10'd480;
            tick();
            tick();
            vc = 10'd0;
            tick();
            if (i == 254) chk("wrap_255", frame_count, 255);
        end
        chk("wrap_0", frame_count, 0);
        chk("wrap_fs", front_sel, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
